chip_74153n_model: RTL and testbench
====================================

Name: chip_74153N_model

Overview:
- Synthesizable behavioural stand-in for a 74153N dual 4-to-1 multiplexer. It sits on the far side of the pin interface from the 74153N checker, so the checker can be exercised on the FPGA without a physical part.
- It takes the checker's driven pins as inputs and drives the two Y output pins back after a configurable pipeline delay.
- It adds fault injection, so the checker's fail path can be verified.
- It adds stimulus-coverage tracking, so a run can be confirmed to have applied every input vector.

Parameters:
- LATENCY, 1, clock cycles from pin change to Y update; legal range 0..4; 0 = purely combinational Y path.
- VEC_CNT_W, 8, width of the vector-change counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Pin1  in  1  1G_n, section-1 strobe, active low.
- Pin2  in  1  select B (MSB), shared by both sections.
- Pin14  in  1  select A (LSB), shared by both sections.
- Pin6, Pin5, Pin4, Pin3  in  1 each  1C0, 1C1, 1C2, 1C3.
- Pin15  in  1  2G_n, section-2 strobe, active low.
- Pin10, Pin11, Pin12, Pin13  in  1 each  2C0, 2C1, 2C2, 2C3.
- Pin7  out  1  1Y.
- Pin9  out  1  2Y.
- Fault_Sel  in  3  fault mode; 0 = healthy.
- Fault_Side  in  1  0 = fault applies to section 1; 1 = fault applies to section 2.
- Cov_Clr  in  1  clears the coverage bitmap and Vec_Count.
- Coverage_Done  out  1  all 128 section-1 vectors have been seen.
- Vec_Count  out  VEC_CNT_W  number of section-1 vector changes seen, saturating.

Behaviour:
- Nominal function per section: Y = ~G_n & C[{B,A}].
- Section-1 vector V1 = {Pin1, Pin2, Pin14, Pin3, Pin4, Pin5, Pin6}, 7 bits.
- Pipeline:
  - Nominal Y, after the fault stage, passes through a LATENCY-deep register chain.
  - With LATENCY=0, Pin7 and Pin9 are combinational from the pins.
  - Fault_Sel and Fault_Side are sampled at the pipeline input, in the same cycle as the pins.
- Fault modes (applied only to the section chosen by Fault_Side; the other section stays nominal):
  - 0: none.
  - 1: Y stuck at 0.
  - 2: Y stuck at 1.
  - 3: Y inverted.
  - 4: A and B swapped for this section.
  - 5: strobe ignored; section always enabled.
  - 6: C1 reads C2 (bridged inputs).
  - 7: intermittent; Y inverted only when the free-running 4-bit tick counter equals 15.
- Tick counter:
  - Increments every cycle and wraps 15->0.
  - Reset sets it to 0.
- Coverage:
  - A 128-bit bitmap; bit V1 is set every cycle that Reset and Cov_Clr are both low.
  - Coverage_Done = AND of all 128 bits; registered, 1-cycle lag after the last bit is set.
  - Prev_V1 is a register updated every cycle.
  - Vec_Count increments when V1 != Prev_V1 and saturates at all-ones (255 by default); it never wraps.
  - The first cycle after reset or Cov_Clr does not count as a change: Prev_V1 is loaded and the compare is suppressed.
  - Cov_Clr together with a bitmap update: clear wins; the bitmap ends all-zero in that cycle.
- Reset:
  - Pin7 = 0 and Pin9 = 0.
  - All pipeline stages = 0.
  - Bitmap = 0, Coverage_Done = 0, Vec_Count = 0, tick counter = 0.
  - Reset mid-run discards in-flight pipeline data.
  - The first valid Y appears LATENCY cycles after Reset deasserts.
- Fault_Sel changes mid-run take effect on the next sampled vector; already-queued pipeline stages are not altered.

Optional Feature:
- Macro: CHIP_MODEL_FAULT_EN.
- When defined: fault logic and the tick counter are present as described above.
- When undefined:
  - Fault_Sel and Fault_Side are ignored.
  - Y is always nominal.
  - The tick counter and fault muxes are not generated.
  - Coverage, Vec_Count and the pipeline are unchanged.

Test Plan:
- Reset, LATENCY=1, Fault_Sel=0; Pin1=0, B=1, A=0, 1C2=1, all other C=0 -> Pin7=1 exactly one cycle later; Pin9=1 because Pin15=0 and 2C2=0... set 2C2=1 too -> Pin9=1.
- Pin1=1 with all C=1 -> Pin7=0 after one cycle; Pin15=0 with 2C3=1, B=A=1 -> Pin9=1.
- Fault_Sel=3, Fault_Side=1; drive nominal 2Y=1 -> Pin9=0 while Pin7 stays nominal.
- Fault_Sel=4, Fault_Side=0; B=1, A=0, 1C1=1, 1C2=0 -> Pin7=1 (nominal would be 0).
- Sweep V1 over 0..127, one per cycle -> Vec_Count=127 and Coverage_Done=1 one cycle after the last vector; pulse Cov_Clr -> both return to 0.
- Fault_Sel=7 from reset with a constant vector giving nominal 1Y=1 -> Pin7=0 only in the cycle after tick=15, i.e. once every 16 cycles; assert Reset mid-sweep -> Pin7=0 and Pin9=0 with counters cleared the next cycle.

Source files
------------

// File: rtl/chip_74153n_model.sv
// -----------------------------------------------------------------------------
// chip_74153n_model
//
// Behavioural stand-in for a 74153N dual 4-to-1 multiplexer. It sits on the
// part side of the pin interface so the 74153N checker can be exercised on
// the FPGA without a physical device. Each section computes
// Y = ~G_n & C[{B,A}]. The result passes through a LATENCY-deep register
// chain before reaching the Y pins. The model also provides selectable
// fault injection and section-1 stimulus coverage tracking.
//
// Optional feature macro: CHIP_MODEL_FAULT_EN
//   defined   : the fault muxes and the free-running 4-bit tick counter are
//               built, and Fault_Sel / Fault_Side select the fault.
//   undefined : Fault_Sel / Fault_Side are ignored and Y is always nominal.
//               Coverage, Vec_Count and the pipeline are the same in both
//               builds.
//
// Parameters
//   LATENCY   : clock cycles from pin change to Y update (legal 0..4).
//               A value of 0 gives a purely combinational Y path.
//   VEC_CNT_W : width of the saturating vector-change counter.
//
// Ports
//   Clk, Reset         : clock, synchronous active-high reset
//   Pin1 / Pin15       : 1G_n / 2G_n strobes (active low)
//   Pin2 / Pin14       : select B (MSB) / select A (LSB), shared by both sections
//   Pin6,Pin5,Pin4,Pin3     : 1C0..1C3
//   Pin10,Pin11,Pin12,Pin13 : 2C0..2C3
//   Pin7 / Pin9        : 1Y / 2Y
//   Fault_Sel          : fault mode (0 = healthy)
//   Fault_Side         : 0 = fault on section 1, 1 = fault on section 2
//   Cov_Clr            : clears the coverage bitmap and Vec_Count
//   Coverage_Done      : all 128 section-1 vectors have been seen
//   Vec_Count          : saturating count of section-1 vector changes
// -----------------------------------------------------------------------------
module chip_74153n_model #(
   parameter int LATENCY   = 1,
   parameter int VEC_CNT_W = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Pin1,
   input  logic                 Pin2,
   input  logic                 Pin14,
   input  logic                 Pin6,
   input  logic                 Pin5,
   input  logic                 Pin4,
   input  logic                 Pin3,
   input  logic                 Pin15,
   input  logic                 Pin10,
   input  logic                 Pin11,
   input  logic                 Pin12,
   input  logic                 Pin13,
   output logic                 Pin7,
   output logic                 Pin9,
   input  logic [2:0]           Fault_Sel,
   input  logic                 Fault_Side,
   input  logic                 Cov_Clr,
   output logic                 Coverage_Done,
   output logic [VEC_CNT_W-1:0] Vec_Count
);

   // Data inputs for each section, indexed by {B,A}.
   logic [3:0] sec1_c;
   logic [3:0] sec2_c;
   logic [6:0] v1;

   assign sec1_c = {Pin3, Pin4, Pin5, Pin6};
   assign sec2_c = {Pin13, Pin12, Pin11, Pin10};
   assign v1     = {Pin1, Pin2, Pin14, Pin3, Pin4, Pin5, Pin6};

   // Healthy 74153 section.
   function automatic logic mux_nominal(input logic       g_n,
                                        input logic       b,
                                        input logic       a,
                                        input logic [3:0] c);
      return ~g_n & c[{b, a}];
   endfunction

   logic [1:0] y_p0;   // {2Y, 1Y} before the register chain

`ifdef CHIP_MODEL_FAULT_EN
   // One section with an optional fault applied. The input-side faults
   // (select swap, strobe ignored, bridged C1/C2) alter the operands before
   // the mux. The output-side faults (stuck, inverted, intermittent) alter
   // the mux result.
   function automatic logic mux_faulty(input logic       g_n,
                                       input logic       b,
                                       input logic       a,
                                       input logic [3:0] c,
                                       input logic [2:0] mode,
                                       input logic       tick_wrap);
      logic [3:0] c_eff;
      logic       b_eff;
      logic       a_eff;
      logic       g_eff;
      logic       y;
      c_eff = c;
      b_eff = b;
      a_eff = a;
      g_eff = g_n;
      case (mode)
         3'd4:    begin b_eff = a; a_eff = b; end
         3'd5:    g_eff = 1'b0;
         3'd6:    c_eff[1] = c[2];
         default: ;
      endcase
      y = mux_nominal(g_eff, b_eff, a_eff, c_eff);
      case (mode)
         3'd1:    y = 1'b0;
         3'd2:    y = 1'b1;
         3'd3:    y = ~y;
         3'd7:    y = y ^ tick_wrap;
         default: ;
      endcase
      return y;
   endfunction

   // Free-running tick counter. It drives the intermittent fault, which
   // fires once every 16 cycles.
   logic [3:0] tick_q;

   always_ff @(posedge Clk) begin
      if (Reset) tick_q <= 4'd0;
      else       tick_q <= tick_q + 4'd1;
   end

   logic [2:0] sec1_mode;
   logic [2:0] sec2_mode;
   logic       tick_wrap;

   // Only the section chosen by Fault_Side sees the fault. The other
   // section gets mode 0, which is nominal.
   assign sec1_mode = Fault_Side ? 3'd0 : Fault_Sel;
   assign sec2_mode = Fault_Side ? Fault_Sel : 3'd0;
   assign tick_wrap = (tick_q == 4'hF);

   // Stage p0: fault stage, sampled in the same cycle as the pins.
   assign y_p0[0] = mux_faulty(Pin1,  Pin2, Pin14, sec1_c, sec1_mode, tick_wrap);
   assign y_p0[1] = mux_faulty(Pin15, Pin2, Pin14, sec2_c, sec2_mode, tick_wrap);
`else
   // Fault controls are intentionally unconnected in this build.
   logic unused_fault;
   assign unused_fault = ^{Fault_Sel, Fault_Side};

   // Stage p0: nominal mux output.
   assign y_p0[0] = mux_nominal(Pin1,  Pin2, Pin14, sec1_c);
   assign y_p0[1] = mux_nominal(Pin15, Pin2, Pin14, sec2_c);
`endif

   // Y delay chain. LATENCY is expected to be in 0..4. A value of 0 bypasses
   // the registers, but Y is still held low during Reset.
   generate
      if (LATENCY == 0) begin : g_comb
         assign {Pin9, Pin7} = Reset ? 2'b00 : y_p0;
      end else begin : g_pipe
         logic [1:0] y_pn [1:LATENCY];

         // Stages p1..pLATENCY. Reset flushes in-flight data.
         always_ff @(posedge Clk) begin
            if (Reset) begin
               for (int i = 1; i <= LATENCY; i++) y_pn[i] <= 2'b00;
            end else begin
               y_pn[1] <= y_p0;
               for (int i = 2; i <= LATENCY; i++) y_pn[i] <= y_pn[i-1];
            end
         end

         assign {Pin9, Pin7} = y_pn[LATENCY];
      end
   endgenerate

   // Coverage bitmap. Cov_Clr has priority over the update, so the
   // bitmap is all-zero after a clear cycle.
   logic [127:0] cov_map_q;

   always_ff @(posedge Clk) begin
      if (Reset || Cov_Clr) cov_map_q     <= '0;
      else                  cov_map_q[v1] <= 1'b1;
   end

   // The done flag is registered from the bitmap, so it rises one cycle
   // after the last bit is set.
   always_ff @(posedge Clk) begin
      if (Reset || Cov_Clr) Coverage_Done <= 1'b0;
      else                  Coverage_Done <= &cov_map_q;
   end

   // Vector-change counter. prev_vld_q suppresses the compare in the first
   // cycle after a reset or clear. In that cycle prev_v1_q is only loaded.
   logic [6:0] prev_v1_q;
   logic       prev_vld_q;

   always_ff @(posedge Clk) begin
      prev_v1_q <= v1;
   end

   always_ff @(posedge Clk) begin
      if (Reset || Cov_Clr) begin
         prev_vld_q <= 1'b0;
         Vec_Count  <= '0;
      end else begin
         prev_vld_q <= 1'b1;
         if (prev_vld_q && (v1 != prev_v1_q) && (Vec_Count != {VEC_CNT_W{1'b1}}))
            Vec_Count <= Vec_Count + 1'b1;
      end
   end

endmodule

// File: tb/tb_chip_74153n_model.sv
module tb_chip_74153n_model;

   logic       Clk;
   logic       Reset;
   logic       Pin1, Pin2, Pin14, Pin6, Pin5, Pin4, Pin3;
   logic       Pin15, Pin10, Pin11, Pin12, Pin13;
   logic       Pin7, Pin9;
   logic [2:0] Fault_Sel;
   logic       Fault_Side;
   logic       Cov_Clr;
   logic       Coverage_Done;
   logic [7:0] Vec_Count;

   int checks;
   int errors;

   chip_74153n_model #(.LATENCY(1), .VEC_CNT_W(8)) dut (
      .Clk(Clk), .Reset(Reset),
      .Pin1(Pin1), .Pin2(Pin2), .Pin14(Pin14),
      .Pin6(Pin6), .Pin5(Pin5), .Pin4(Pin4), .Pin3(Pin3),
      .Pin15(Pin15), .Pin10(Pin10), .Pin11(Pin11), .Pin12(Pin12), .Pin13(Pin13),
      .Pin7(Pin7), .Pin9(Pin9),
      .Fault_Sel(Fault_Sel), .Fault_Side(Fault_Side),
      .Cov_Clr(Cov_Clr), .Coverage_Done(Coverage_Done), .Vec_Count(Vec_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // V1 = {1G_n, B, A, 1C3, 1C2, 1C1, 1C0}
   task automatic set_v1(input logic [6:0] v);
      {Pin1, Pin2, Pin14, Pin3, Pin4, Pin5, Pin6} = v;
   endtask

   task automatic set_s2(input logic g_n, input logic [3:0] c);
      Pin15 = g_n;
      {Pin13, Pin12, Pin11, Pin10} = c;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Cov_Clr = 1'b0; Fault_Sel = 3'd0; Fault_Side = 1'b0;
      set_v1(7'b0100100); set_s2(1'b0, 4'b0100);
      step(); step();
      checks++; if (Pin7 !== 1'b0) begin errors++; $display("FAIL reset_pin7 got %b exp 0", Pin7); end
      checks++; if (Pin9 !== 1'b0) begin errors++; $display("FAIL reset_pin9 got %b exp 0", Pin9); end
      checks++; if (Vec_Count !== 8'd0) begin errors++; $display("FAIL reset_vec_count got %0d exp 0", Vec_Count); end
      checks++; if (Coverage_Done !== 1'b0) begin errors++; $display("FAIL reset_cov_done got %b exp 0", Coverage_Done); end
      Reset = 1'b0;
      // First valid Y one cycle after reset release.
      step();
      checks++; if (Pin7 !== 1'b1) begin errors++; $display("FAIL first_y_pin7 got %b exp 1", Pin7); end
      checks++; if (Pin9 !== 1'b1) begin errors++; $display("FAIL first_y_pin9 got %b exp 1", Pin9); end
   endtask

   task automatic test_nominal();
      logic [6:0] tv1 [5];
      logic       tg2 [5];
      logic [3:0] tc2 [5];
      logic       e7  [5];
      logic       e9  [5];
      tv1[0] = 7'b0100100; tg2[0] = 1'b0; tc2[0] = 4'b0100; e7[0] = 1'b1; e9[0] = 1'b1;
      tv1[1] = 7'b1111111; tg2[1] = 1'b0; tc2[1] = 4'b1000; e7[1] = 1'b0; e9[1] = 1'b1;
      tv1[2] = 7'b0110111; tg2[2] = 1'b1; tc2[2] = 4'b1111; e7[2] = 1'b0; e9[2] = 1'b0;
      tv1[3] = 7'b0000001; tg2[3] = 1'b0; tc2[3] = 4'b1110; e7[3] = 1'b1; e9[3] = 1'b0;
      tv1[4] = 7'b0010010; tg2[4] = 1'b0; tc2[4] = 4'b0010; e7[4] = 1'b1; e9[4] = 1'b1;
      // Latency: a pin change must not reach Y before the clock edge.
      set_v1(7'b0000000); set_s2(1'b0, 4'b0000);
      step();
      set_v1(tv1[0]); set_s2(tg2[0], tc2[0]);
      #1;
      checks++; if (Pin7 !== 1'b0) begin errors++; $display("FAIL latency_pin7 got %b exp 0", Pin7); end
      for (int i = 0; i < 5; i++) begin
         set_v1(tv1[i]); set_s2(tg2[i], tc2[i]);
         step();
         checks++; if (Pin7 !== e7[i]) begin errors++; $display("FAIL nominal_pin7[%0d] got %b exp %b", i, Pin7, e7[i]); end
         checks++; if (Pin9 !== e9[i]) begin errors++; $display("FAIL nominal_pin9[%0d] got %b exp %b", i, Pin9, e9[i]); end
      end
   endtask

`ifdef CHIP_MODEL_FAULT_EN
   task automatic test_faults();
      logic [2:0] fs  [7];
      logic       fsd [7];
      logic [6:0] tv1 [7];
      logic       tg2 [7];
      logic [3:0] tc2 [7];
      logic       e7  [7];
      logic       e9  [7];
      fs[0] = 3'd3; fsd[0] = 1'b1; tv1[0] = 7'b0100100; tg2[0] = 1'b0; tc2[0] = 4'b0100; e7[0] = 1'b1; e9[0] = 1'b0;
      fs[1] = 3'd4; fsd[1] = 1'b0; tv1[1] = 7'b0100010; tg2[1] = 1'b0; tc2[1] = 4'b0100; e7[1] = 1'b1; e9[1] = 1'b1;
      fs[2] = 3'd1; fsd[2] = 1'b0; tv1[2] = 7'b0100100; tg2[2] = 1'b0; tc2[2] = 4'b0100; e7[2] = 1'b0; e9[2] = 1'b1;
      fs[3] = 3'd2; fsd[3] = 1'b1; tv1[3] = 7'b0100100; tg2[3] = 1'b1; tc2[3] = 4'b0100; e7[3] = 1'b1; e9[3] = 1'b1;
      fs[4] = 3'd5; fsd[4] = 1'b0; tv1[4] = 7'b1100100; tg2[4] = 1'b1; tc2[4] = 4'b0100; e7[4] = 1'b1; e9[4] = 1'b0;
      fs[5] = 3'd6; fsd[5] = 1'b1; tv1[5] = 7'b0010000; tg2[5] = 1'b0; tc2[5] = 4'b0100; e7[5] = 1'b0; e9[5] = 1'b1;
      fs[6] = 3'd0; fsd[6] = 1'b1; tv1[6] = 7'b0010000; tg2[6] = 1'b0; tc2[6] = 4'b0100; e7[6] = 1'b0; e9[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         Fault_Sel = fs[i]; Fault_Side = fsd[i];
         set_v1(tv1[i]); set_s2(tg2[i], tc2[i]);
         step();
         checks++; if (Pin7 !== e7[i]) begin errors++; $display("FAIL fault_pin7[%0d] got %b exp %b", i, Pin7, e7[i]); end
         checks++; if (Pin9 !== e9[i]) begin errors++; $display("FAIL fault_pin9[%0d] got %b exp %b", i, Pin9, e9[i]); end
      end
      Fault_Sel = 3'd0; Fault_Side = 1'b0;
   endtask

   task automatic test_intermittent();
      logic e;
      Reset = 1'b1; Fault_Sel = 3'd7; Fault_Side = 1'b0;
      set_v1(7'b0100100); set_s2(1'b1, 4'b1111);
      step();
      Reset = 1'b0;
      // Edge k samples tick = k-1; Y is inverted when tick was 15.
      for (int k = 1; k <= 40; k++) begin
         step();
         e = (((k - 1) % 16) == 15) ? 1'b0 : 1'b1;
         checks++; if (Pin7 !== e) begin errors++; $display("FAIL intermittent_pin7[%0d] got %b exp %b", k, Pin7, e); end
      end
      checks++; if (Pin9 !== 1'b0) begin errors++; $display("FAIL intermittent_pin9 got %b exp 0", Pin9); end
      // 1C0 is not selected, so toggling it changes V1 but not 1Y.
      set_v1(7'b0100101);
      step();
      checks++; if (Vec_Count !== 8'd1) begin errors++; $display("FAIL pre_reset_vec_count got %0d exp 1", Vec_Count); end
      set_s2(1'b0, 4'b0100);
      Reset = 1'b1;
      step();
      checks++; if (Pin7 !== 1'b0) begin errors++; $display("FAIL midreset_pin7 got %b exp 0", Pin7); end
      checks++; if (Pin9 !== 1'b0) begin errors++; $display("FAIL midreset_pin9 got %b exp 0", Pin9); end
      checks++; if (Vec_Count !== 8'd0) begin errors++; $display("FAIL midreset_vec_count got %0d exp 0", Vec_Count); end
      Reset = 1'b0; set_s2(1'b1, 4'b1111);
      for (int k = 1; k <= 17; k++) begin
         step();
         e = (((k - 1) % 16) == 15) ? 1'b0 : 1'b1;
         checks++; if (Pin7 !== e) begin errors++; $display("FAIL tick_restart_pin7[%0d] got %b exp %b", k, Pin7, e); end
      end
      Fault_Sel = 3'd0;
   endtask
`else
   task automatic test_faults_ignored();
      Fault_Sel = 3'd3; Fault_Side = 1'b0;
      set_v1(7'b0100100); set_s2(1'b0, 4'b0100);
      step();
      checks++; if (Pin7 !== 1'b1) begin errors++; $display("FAIL nofault_pin7 got %b exp 1", Pin7); end
      Fault_Sel = 3'd1; Fault_Side = 1'b1;
      step();
      checks++; if (Pin9 !== 1'b1) begin errors++; $display("FAIL nofault_pin9 got %b exp 1", Pin9); end
      Reset = 1'b1;
      step();
      checks++; if (Pin7 !== 1'b0) begin errors++; $display("FAIL midreset_pin7 got %b exp 0", Pin7); end
      checks++; if (Pin9 !== 1'b0) begin errors++; $display("FAIL midreset_pin9 got %b exp 0", Pin9); end
      Reset = 1'b0;
      step();
      checks++; if (Pin7 !== 1'b1) begin errors++; $display("FAIL post_reset_pin7 got %b exp 1", Pin7); end
      Fault_Sel = 3'd0; Fault_Side = 1'b0;
   endtask
`endif

   task automatic test_coverage();
      set_v1(7'd0);
      Cov_Clr = 1'b1;
      step();
      Cov_Clr = 1'b0;
      checks++; if (Vec_Count !== 8'd0) begin errors++; $display("FAIL clr_vec_count got %0d exp 0", Vec_Count); end
      for (int i = 0; i < 128; i++) begin
         set_v1(7'(i));
         step();
         if (i == 0) begin
            checks++; if (Vec_Count !== 8'd0) begin errors++; $display("FAIL first_vec_suppressed got %0d exp 0", Vec_Count); end
         end
         if (i == 126) begin
            checks++; if (Coverage_Done !== 1'b0) begin errors++; $display("FAIL cov_done_early got %b exp 0", Coverage_Done); end
         end
      end
      checks++; if (Vec_Count !== 8'd127) begin errors++; $display("FAIL sweep_vec_count got %0d exp 127", Vec_Count); end
      checks++; if (Coverage_Done !== 1'b0) begin errors++; $display("FAIL cov_done_lag got %b exp 0", Coverage_Done); end
      step();
      checks++; if (Coverage_Done !== 1'b1) begin errors++; $display("FAIL cov_done got %b exp 1", Coverage_Done); end
      checks++; if (Vec_Count !== 8'd127) begin errors++; $display("FAIL hold_vec_count got %0d exp 127", Vec_Count); end
      Cov_Clr = 1'b1;
      step();
      Cov_Clr = 1'b0;
      checks++; if (Coverage_Done !== 1'b0) begin errors++; $display("FAIL clr_cov_done got %b exp 0", Coverage_Done); end
      checks++; if (Vec_Count !== 8'd0) begin errors++; $display("FAIL clr_vec_count2 got %0d exp 0", Vec_Count); end
      // Clear won over the update, so one new bit cannot complete the map.
      step(); step();
      checks++; if (Coverage_Done !== 1'b0) begin errors++; $display("FAIL clr_wins got %b exp 0", Coverage_Done); end
   endtask

   task automatic test_saturate();
      set_v1(7'd0);
      Cov_Clr = 1'b1;
      step();
      Cov_Clr = 1'b0;
      for (int n = 1; n <= 300; n++) begin
         set_v1(7'(n & 1));
         step();
         if (n == 255) begin
            checks++; if (Vec_Count !== 8'd254) begin errors++; $display("FAIL count_254 got %0d exp 254", Vec_Count); end
         end
         if (n == 256) begin
            checks++; if (Vec_Count !== 8'd255) begin errors++; $display("FAIL count_255 got %0d exp 255", Vec_Count); end
         end
      end
      checks++; if (Vec_Count !== 8'd255) begin errors++; $display("FAIL count_saturated got %0d exp 255", Vec_Count); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Reset = 1'b1; Cov_Clr = 1'b0; Fault_Sel = 3'd0; Fault_Side = 1'b0;
      set_v1(7'd0); set_s2(1'b1, 4'd0);
      test_reset();
      test_nominal();
`ifdef CHIP_MODEL_FAULT_EN
      test_faults();
      test_intermittent();
`else
      test_faults_ignored();
`endif
      test_coverage();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
